// File: rtl/rr_mux_pkg.sv
// Shared constants for the round-robin 2:1 mux stage: channel ids and output-register state encoding.
package rr_mux_pkg;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  typedef logic [0:0] state_t;
  localparam state_t ST_EMPTY = 1'b0;
  localparam state_t ST_FULL  = 1'b1;

endpackage

// File: rtl/rr_mux2_stage_if.sv
// Two producer channels, one registered consumer channel and per-channel transfer counters.
interface rr_mux2_stage_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in0_valid;
  logic [WIDTH-1:0] in0_data;
  logic             in0_ready;
  logic             in1_valid;
  logic [WIDTH-1:0] in1_data;
  logic             in1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_sel;
  logic             out_ready;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  modport master (
    output in0_valid, in0_data, in1_valid, in1_data, out_ready,
    input  in0_ready, in1_ready, out_valid, out_data, out_sel, cnt0, cnt1
  );

  modport slave (
    input  in0_valid, in0_data, in1_valid, in1_data, out_ready,
    output in0_ready, in1_ready, out_valid, out_data, out_sel, cnt0, cnt1
  );
endinterface

// File: rtl/rr_mux2_stage_arb2.sv
// Combinational two-way round-robin arbiter: grants the requester that did not win last.
// Zero latency; en=0 suppresses every grant.
module rr_arb2
  import rr_mux_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       en,
  output logic [1:0] gnt
);

  assign gnt[0] = en && req[0] && (!req[1] || (last == CH1));
  assign gnt[1] = en && req[1] && (!req[0] || (last == CH0));

endmodule

// File: rtl/rr_mux2_stage.sv
// Round-robin 2:1 mux stage with a registered output word, source select and saturating counters.
// Latency 1 cycle; ready is withheld from both producers while the held word is not taken.
module rr_mux2_stage
  import rr_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
)(
  input logic             clk,
  input logic             rst,
  rr_mux2_stage_if.slave  bus
);

  state_t           state;
  logic             last;
  logic [WIDTH-1:0] data_q;
  logic             sel_q;
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;
  logic             can_load;
  logic [1:0]       gnt;

  assign can_load = (state == ST_EMPTY) || bus.out_ready;

  // Holding off grants during reset keeps producers from losing a word that reset would discard.
  rr_arb2 u_arb (
    .req ({bus.in1_valid, bus.in0_valid}),
    .last(last),
    .en  (can_load && !rst),
    .gnt (gnt)
  );

  assign bus.in0_ready = gnt[0];
  assign bus.in1_ready = gnt[1];
  assign bus.out_valid = (state == ST_FULL);
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
  assign bus.cnt0      = cnt0_q;
  assign bus.cnt1      = cnt1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_EMPTY;
      data_q <= '0;
      sel_q  <= CH0;
      last   <= CH1;
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (gnt != 2'b00) begin
        state  <= ST_FULL;
        data_q <= gnt[1] ? bus.in1_data : bus.in0_data;
        sel_q  <= gnt[1] ? CH1 : CH0;
        last   <= gnt[1] ? CH1 : CH0;
      end else if (bus.out_ready) begin
        state  <= ST_EMPTY;
      end
      if (gnt[0] && (cnt0_q != '1)) cnt0_q <= cnt0_q + 1'b1;
      if (gnt[1] && (cnt1_q != '1)) cnt1_q <= cnt1_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_mux2_stage.sv
// Scoreboard bench for rr_mux2_stage: a reference model predicts grants, words and counters each cycle.
module tb_rr_mux2_stage;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef struct packed {
    logic             sel;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  exp_t             sb[$];
  logic             m_valid;
  logic             m_last;
  logic [CNT_W-1:0] m_c0;
  logic [CNT_W-1:0] m_c1;

  rr_mux2_stage_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  rr_mux2_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Checks DUT against the model at negedge, then advances the model across the posedge.
  task automatic step();
    logic can, g0, g1;
    exp_t e;
    @(negedge clk);
    chk("out_valid", bus.out_valid, m_valid);
    if (m_valid) begin
      chk("sb_depth", sb.size(), 1);
      if (sb.size() > 0) begin
        chk("out_data", bus.out_data, sb[0].data);
        chk("out_sel", bus.out_sel, sb[0].sel);
      end
    end
    can = !m_valid || bus.out_ready;
    g0  = can && !rst && bus.in0_valid && (!bus.in1_valid || m_last);
    g1  = can && !rst && bus.in1_valid && (!bus.in0_valid || !m_last);
    chk("in0_ready", bus.in0_ready, g0);
    chk("in1_ready", bus.in1_ready, g1);
    chk("cnt0", bus.cnt0, m_c0);
    chk("cnt1", bus.cnt1, m_c1);
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 1'b0;
      m_last  = 1'b1;
      m_c0    = '0;
      m_c1    = '0;
      sb.delete();
    end else begin
      if (m_valid && bus.out_ready && sb.size() > 0) void'(sb.pop_front());
      if (g0 || g1) begin
        e.sel  = g1;
        e.data = g1 ? bus.in1_data : bus.in0_data;
        sb.push_back(e);
        m_valid = 1'b1;
        m_last  = g1;
        if (g0 && m_c0 != CNT_MAX) m_c0 = m_c0 + 1'b1;
        if (g1 && m_c1 != CNT_MAX) m_c1 = m_c1 + 1'b1;
      end else if (bus.out_ready) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic idle();
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    m_valid = 1'b0;
    m_last  = 1'b1;
    m_c0    = '0;
    m_c1    = '0;

    // Reset held two cycles with both producers requesting.
    rst = 1'b1;
    bus.in0_valid = 1'b1; bus.in0_data = 8'hA5;
    bus.in1_valid = 1'b1; bus.in1_data = 8'h3C;
    bus.out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    idle();
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_sel", bus.out_sel, 0);
    chk("rst_out_valid", bus.out_valid, 0);

    // Single source on ch0.
    bus.in0_valid = 1'b1; bus.in0_data = 8'h11;
    step();
    idle();
    chk("single_data", bus.out_data, 8'h11);
    chk("single_cnt0", bus.cnt0, 1);
    step();

    // Contention from a fresh reset: strict 0,1,0,1,0,1.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bus.in0_valid = 1'b1; bus.in0_data = 8'(i);
      bus.in1_valid = 1'b1; bus.in1_data = 8'(8'h80 + i);
      step();
      chk("alt_sel", bus.out_sel, i % 2);
    end
    idle();
    step();
    chk("alt_cnt0", bus.cnt0, 3);
    chk("alt_cnt1", bus.cnt1, 3);

    // Backpressure: 22 held while ch1 waits, then same-cycle reload with 33.
    do_reset();
    bus.in0_valid = 1'b1; bus.in0_data = 8'h22;
    step();
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b1; bus.in1_data = 8'h33;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold", bus.out_data, 8'h22);
    end
    bus.out_ready = 1'b1;
    step();
    chk("bp_reload", bus.out_data, 8'h33);
    chk("bp_reload_sel", bus.out_sel, 1);
    idle();
    step();
    step();

    // Saturation: five ch1 transfers into a 2-bit counter.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.in1_valid = 1'b1; bus.in1_data = 8'(8'h40 + i);
      step();
    end
    idle();
    step();
    chk("sat_cnt1", bus.cnt1, 3);

    // Reset while FULL drops the word; the next contest goes to ch0.
    bus.in0_valid = 1'b1; bus.in0_data = 8'h5A;
    step();
    bus.in0_valid = 1'b0;
    bus.out_ready = 1'b0;
    step();
    rst = 1'b1;
    bus.in0_valid = 1'b1;
    bus.in1_valid = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_cnt0", bus.cnt0, 0);
    chk("mid_rst_cnt1", bus.cnt1, 0);
    bus.out_ready = 1'b1;
    bus.in0_data = 8'h61; bus.in1_data = 8'h62;
    step();
    chk("mid_rst_first", bus.out_sel, 0);
    idle();
    step();
    step();
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
